// File: rtl/deser_fila_param_pkg.sv
// Shared types and width helpers for the serial-to-word deserializer and its word queue.
package deser_fila_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } des_state_t;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Divider counter width; a divide-by-one counter still needs one bit.
  function automatic int cnt_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/deser_fila_param_if.sv
// Serial-in / word-out bus of the deserializer queue; slave is the design side.
interface deser_fila_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  import deser_fila_pkg::*;

  logic                      data_in;
  logic                      write_in;
  logic                      dequeue_in;
  logic [DATA_W-1:0]         data_out;
  logic                      valid_out;
  logic                      status_out;
  logic [len_w(DEPTH)-1:0]   len_out;
  logic                      full_out;
  logic                      empty_out;
  logic                      overflow_out;

  modport master (
    output data_in, write_in, dequeue_in,
    input  data_out, valid_out, status_out, len_out, full_out, empty_out, overflow_out
  );

  modport slave (
    input  data_in, write_in, dequeue_in,
    output data_out, valid_out, status_out, len_out, full_out, empty_out, overflow_out
  );

endinterface

// File: rtl/deser_fila_param_tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clocks.
module tick_gen
  import deser_fila_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clock1M,
  input  logic reset,
  output logic tick_out
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick_out = (cnt_reg == LAST);

endmodule

// File: rtl/deser_fila_param.sv
// Serial bit collector feeding a circular word queue; all timing from clock-enable ticks.
module deser_fila_param
  import deser_fila_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int DES_DIV   = 10,
  parameter int FIFO_DIV  = 100,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clock1M,
  input  logic                 reset,
  deser_fila_param_if.slave    bus
);

  localparam int LW = len_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_W);

  logic              tick_des;
  logic              tick_fifo;
  des_state_t        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BW-1:0]     bit_cnt_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     len_reg, len_next;
  logic              full_reg, empty_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              valid_reg;
  logic              overflow_reg;
  logic              take_bit, last_bit, enq, deq, ovf_evt;

  tick_gen #(.DIV(DES_DIV)) u_tick_des (
    .clock1M  (clock1M),
    .reset    (reset),
    .tick_out (tick_des)
  );

  tick_gen #(.DIV(FIFO_DIV)) u_tick_fifo (
    .clock1M  (clock1M),
    .reset    (reset),
    .tick_out (tick_fifo)
  );

  assign take_bit = (state_reg == COLLECT) && tick_des && bus.write_in;
  assign last_bit = take_bit && (bit_cnt_reg == BW'(DATA_W - 1));
  // Queue eligibility is judged on the occupancy before this tick.
  assign enq      = (state_reg == HOLD) && tick_fifo && (len_reg != LW'(DEPTH));
  assign ovf_evt  = (state_reg == HOLD) && tick_fifo && (len_reg == LW'(DEPTH));
  assign deq      = tick_fifo && bus.dequeue_in && (len_reg != '0);

  // Bit order decides which end the incoming bit enters from.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_in
          assign shift_next[gi] = bus.data_in;
        end else begin : g_mv
          assign shift_next[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == DATA_W - 1) begin : g_in
          assign shift_next[gi] = bus.data_in;
        end else begin : g_mv
          assign shift_next[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (last_bit) state_next = HOLD;
      HOLD:    if (enq)      state_next = COLLECT;
      default:               state_next = COLLECT;
    endcase
  end

  always_comb begin
    bus.status_out = (state_reg == COLLECT);
  end

  always_comb begin
    len_next = len_reg;
    if (enq && !deq) begin
      len_next = len_reg + LW'(1);
    end else if (!enq && deq) begin
      len_next = len_reg - LW'(1);
    end
  end

  always_ff @(posedge clock1M) begin
    if (enq) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      len_reg      <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      valid_reg <= deq;
      if (take_bit) begin
        shift_reg   <= shift_next;
        bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + BW'(1);
      end
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (deq) begin
        data_out_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + PW'(1);
      end
      if (ovf_evt) begin
        overflow_reg <= 1'b1;
      end
      len_reg   <= len_next;
      full_reg  <= (len_next == LW'(DEPTH));
      empty_reg <= (len_next == '0);
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.valid_out    = valid_reg;
  assign bus.len_out      = len_reg;
  assign bus.full_out     = full_reg;
  assign bus.empty_out    = empty_reg;
  assign bus.overflow_out = overflow_reg;

endmodule

// File: tb/tb_deser_fila_param.sv
// Directed bench: two instances (MSB-first and LSB-first) checked every cycle against a queue-based model.
module tb_deser_fila_param;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int DES_DIV  = 2;
  localparam int FIFO_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic data_in    = 1'b0;
  logic write_in   = 1'b0;
  logic dequeue_in = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  deser_fila_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_msb ();
  deser_fila_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_lsb ();

  assign if_msb.data_in    = data_in;
  assign if_msb.write_in   = write_in;
  assign if_msb.dequeue_in = dequeue_in;
  assign if_lsb.data_in    = data_in;
  assign if_lsb.write_in   = write_in;
  assign if_lsb.dequeue_in = dequeue_in;

  deser_fila_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DES_DIV(DES_DIV),
                     .FIFO_DIV(FIFO_DIV), .MSB_FIRST(1)) dut_msb (
    .clock1M (clk),
    .reset   (rst_n),
    .bus     (if_msb)
  );

  deser_fila_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DES_DIV(DES_DIV),
                     .FIFO_DIV(FIFO_DIV), .MSB_FIRST(0)) dut_lsb (
    .clock1M (clk),
    .reset   (rst_n),
    .bus     (if_lsb)
  );

  // Model state: words are kept in arrival order with the first bit as MSB.
  int          n_cyc = 0;
  bit          last_tick_d = 0, last_tick_f = 0;
  int          nbits = 0;
  bit          held = 0;
  logic [7:0]  cur_w = '0, held_w = '0;
  logic [7:0]  q[$];
  logic [7:0]  m_data = '0;
  bit          m_valid = 0, m_ovf = 0;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n_cyc = 0; nbits = 0; held = 0; cur_w = '0; held_w = '0;
        q.delete(); m_data = '0; m_valid = 0; m_ovf = 0;
        last_tick_d = 0; last_tick_f = 0;
      end else begin
        bit td, tf, was_held;
        int pre_len;
        td = (n_cyc % DES_DIV) == DES_DIV - 1;
        tf = (n_cyc % FIFO_DIV) == FIFO_DIV - 1;
        n_cyc++;
        pre_len  = q.size();
        was_held = held;
        m_valid  = 0;
        if (tf && dequeue_in && pre_len > 0) begin
          m_data  = q.pop_front();
          m_valid = 1;
        end
        if (was_held && tf) begin
          if (pre_len < DEPTH) begin
            q.push_back(held_w);
            held = 0;
          end else begin
            m_ovf = 1;
          end
        end
        if (!was_held && td && write_in) begin
          cur_w[DATA_W-1-nbits] = data_in;
          nbits++;
          if (nbits == DATA_W) begin
            held   = 1;
            held_w = cur_w;
            nbits  = 0;
          end
        end
        last_tick_d = td;
        last_tick_f = tf;
      end
    end
  end

  always @(negedge clk) begin
    chk("msb_data",  if_msb.data_out,     m_data);
    chk("lsb_data",  if_lsb.data_out,     rev8(m_data));
    chk("msb_valid", if_msb.valid_out,    m_valid);
    chk("lsb_valid", if_lsb.valid_out,    m_valid);
    chk("msb_stat",  if_msb.status_out,   !held);
    chk("lsb_stat",  if_lsb.status_out,   !held);
    chk("msb_len",   if_msb.len_out,      q.size());
    chk("lsb_len",   if_lsb.len_out,      q.size());
    chk("msb_full",  if_msb.full_out,     q.size() == DEPTH);
    chk("lsb_full",  if_lsb.full_out,     q.size() == DEPTH);
    chk("msb_empty", if_msb.empty_out,    q.size() == 0);
    chk("lsb_empty", if_lsb.empty_out,    q.size() == 0);
    chk("msb_ovf",   if_msb.overflow_out, m_ovf);
    chk("lsb_ovf",   if_lsb.overflow_out, m_ovf);
  end

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s: got no event, expected one within budget at %0t", name, $time);
  endtask

  task automatic wait_dtick();
    int k = 0;
    do begin @(negedge clk); k++; end while (!last_tick_d && k < 64);
    if (!last_tick_d) timeout("dtick");
  endtask

  task automatic wait_ftick();
    int k = 0;
    do begin @(negedge clk); k++; end while (!last_tick_f && k < 64);
    if (!last_tick_f) timeout("ftick");
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    wait_dtick();
    write_in = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    $display("sent word %02h", w);
  endtask

  task automatic wait_enq();
    int k = 0;
    while (held && k < 64) begin @(negedge clk); k++; end
    if (held) timeout("enqueue");
  endtask

  task automatic deq_once();
    dequeue_in = 1'b1;
    wait_ftick();
    dequeue_in = 1'b0;
    $display("dequeue: msb=%02h lsb=%02h valid=%0b len=%0d",
             if_msb.data_out, if_lsb.data_out, if_msb.valid_out, if_msb.len_out);
  endtask

  initial begin
    logic [7:0] w3c;
    repeat (3) @(negedge clk);
    chk("rst_len", if_msb.len_out, 0);
    chk("rst_empty", if_msb.empty_out, 1);
    rst_n = 1'b1;

    // MSB/LSB bit order
    send_word(8'hA5);
    wait_enq();
    chk("a5_len", if_msb.len_out, 1);
    deq_once();
    chk("a5_msb", if_msb.data_out, 8'hA5);
    chk("a5_lsb", if_lsb.data_out, 8'hA5);
    chk("a5_valid", if_msb.valid_out, 1);
    @(negedge clk);
    chk("a5_pulse", if_msb.valid_out, 0);
    send_word(8'hC0);
    wait_enq();
    deq_once();
    chk("c0_msb", if_msb.data_out, 8'hC0);
    chk("03_lsb", if_lsb.data_out, 8'h03);

    // Pause mid-word: idle ticks with data_in high must not be captured
    w3c = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(w3c[i]);
    data_in = 1'b1;
    repeat (5) wait_dtick();
    for (int i = 3; i >= 0; i--) send_bit(w3c[i]);
    wait_enq();
    deq_once();
    chk("3c_msb", if_msb.data_out, 8'h3C);
    chk("3c_lsb", if_lsb.data_out, 8'h3C);

    // Dequeue from empty queue
    deq_once();
    chk("empty_valid", if_msb.valid_out, 0);
    chk("empty_hold", if_msb.data_out, 8'h3C);

    // Asynchronous reset mid-word with a word queued
    send_word(8'h5A);
    wait_enq();
    chk("pre_rst_len", if_msb.len_out, 1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_len", if_msb.len_out, 0);
    chk("arst_stat", if_msb.status_out, 1);
    chk("arst_data", if_msb.data_out, 0);
    chk("arst_empty", if_lsb.empty_out, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h96);
    wait_enq();
    chk("fresh_len", if_msb.len_out, 1);
    deq_once();
    chk("96_msb", if_msb.data_out, 8'h96);
    chk("69_lsb", if_lsb.data_out, 8'h69);

    // Fill to full, then overflow with a held word
    send_word(8'h11); wait_enq();
    send_word(8'h22); wait_enq();
    send_word(8'h33); wait_enq();
    send_word(8'h44); wait_enq();
    chk("full_len", if_msb.len_out, 4);
    chk("full_flag", if_msb.full_out, 1);
    send_word(8'h55);
    chk("hold_stat", if_msb.status_out, 0);
    wait_ftick();
    chk("ovf_set", if_msb.overflow_out, 1);
    chk("ovf_len", if_msb.len_out, 4);
    deq_once();
    chk("ovf_deq", if_msb.data_out, 8'h11);
    chk("ovf_len3", if_msb.len_out, 3);
    chk("ovf_stat", if_msb.status_out, 0);
    wait_ftick();
    chk("late_enq", if_msb.len_out, 4);
    chk("late_stat", if_msb.status_out, 1);
    chk("ovf_sticky", if_lsb.overflow_out, 1);

    // Simultaneous enqueue/dequeue and pointer wrap
    deq_once(); chk("w22", if_msb.data_out, 8'h22);
    deq_once(); chk("w33", if_msb.data_out, 8'h33);
    send_word(8'h66);
    deq_once();
    chk("sim_len", if_msb.len_out, 2);
    chk("sim_data", if_msb.data_out, 8'h44);
    chk("sim_stat", if_msb.status_out, 1);
    deq_once(); chk("w55", if_msb.data_out, 8'h55);
    deq_once(); chk("w66", if_msb.data_out, 8'h66);
    chk("drain_empty", if_msb.empty_out, 1);
    deq_once();
    chk("drain_valid", if_msb.valid_out, 0);
    chk("drain_hold", if_lsb.data_out, 8'h66);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
